// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage feeding decode.
// Owns the fetch PC, issues credit-limited requests to instruction memory,
// tracks the PCs of outstanding requests, buffers returned words with their
// PCs, and flushes/discards work on a branch or jump redirect.
// Address bit 31 here is the memory interface's "bit 0" (the MSB).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;   // ring pointer width
    localparam int CW = $clog2(DEPTH + 1);      // counter width, holds 0..DEPTH

    // control state
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] pcq_rd_q, pcq_rd_d;
    logic [PW-1:0] pcq_wr_q, pcq_wr_d;

    // storage, not reset: contents are only meaningful under the counters
    logic [31:0]   pcq_q       [DEPTH];
    logic [31:0]   fifo_insn_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic          pop;
    logic          grant;
    logic          fifo_push;
    logic [CW:0]   credit_used;

    // low two bits of a redirect target are dropped (word alignment)
    logic          unused_rpc_low;
    assign unused_rpc_low = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // request credit, grant/pop/push qualification
    always_comb begin
        pop         = (occ_q != '0) && !stall;
        credit_used = {1'b0, out_cnt_q} + {1'b0, occ_q} - {{CW{1'b0}}, pop};
        imem_req    = !reset && !redirect && (credit_used < (CW+1)'(DEPTH));
        imem_addr   = fpc_q;
        grant       = imem_req && imem_gnt;
        fifo_push   = imem_rvalid && !redirect && (drop_cnt_q == '0);
    end

    // next-state for PC, counters and ring pointers; redirect has priority
    always_comb begin
        fpc_d      = fpc_q;
        out_cnt_d  = out_cnt_q + CW'(grant) - CW'(imem_rvalid);
        drop_cnt_d = drop_cnt_q;
        occ_d      = occ_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        pcq_wr_d   = grant       ? ptr_inc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d   = imem_rvalid ? ptr_inc(pcq_rd_q) : pcq_rd_q;

        if (redirect) begin
            fpc_d      = {redirect_pc[31:2], 2'b00};
            // everything still in flight is stale, including a response arriving now
            drop_cnt_d = out_cnt_q - CW'(imem_rvalid);
            occ_d      = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
        end else begin
            if (grant) begin
                fpc_d = fpc_q + 32'd4;
            end
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            occ_d = occ_q + CW'(fifo_push) - CW'(pop);
            if (fifo_push) begin
                fifo_wr_d = ptr_inc(fifo_wr_q);
            end
            if (pop) begin
                fifo_rd_d = ptr_inc(fifo_rd_q);
            end
        end
    end

    // control registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q      <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            occ_q      <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
        end else begin
            fpc_q      <= fpc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            occ_q      <= occ_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
        end
    end

    // PC queue and instruction buffer data writes
    always_ff @(posedge clk) begin
        if (grant) begin
            pcq_q[pcq_wr_q] <= fpc_q;
        end
        if (fifo_push) begin
            fifo_insn_q[fifo_wr_q] <= imem_rdata;
            fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
        end
    end

    // decode sees the buffer head, or a zero noop when empty
    always_comb begin
        valid_insn = (occ_q != '0);
        insn       = valid_insn ? fifo_insn_q[fifo_rd_q] : 32'h0;
        pc         = valid_insn ? fifo_pc_q[fifo_rd_q]   : 32'h0;
    end

    // the credit rule must keep the buffer from overflowing
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && !pop && (occ_q == CW'(DEPTH))));

    // a response can only answer a request that was granted
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && (out_cnt_q == '0)));

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of decode.
- Owns the fetch PC and issues requests to instruction memory over a request/grant plus in-order response interface.
- Buffers returned instructions together with their PCs and presents them to decode as insn/pc/valid_insn, holding them under stall.
- Handles branch/jump redirects by flushing buffered work and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h00000000: fetch address after reset.
- DEPTH, 2: instruction buffer entries; also the bound on outstanding requests plus buffered entries (legal values 2..4).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, bits [0:31], bit 0 is the MSB, word aligned.
- imem_gnt  in  1  request accepted this cycle (counts only when imem_req=1).
- imem_rvalid  in  1  response valid; responses arrive in request order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- stall  in  1  decode or hazard logic is not consuming this cycle.
- redirect  in  1  taken branch or jump; restart fetch.
- redirect_pc  in  32  new fetch address.
- insn  out  32  instruction to decode.
- pc  out  32  PC of insn.
- valid_insn  out  1  insn/pc are valid.

Behaviour:
State:
- fpc: fetch PC.
- out_cnt: outstanding granted requests, range 0..DEPTH.
- drop_cnt: in-flight responses to discard, never greater than out_cnt.
- PC queue: holds the PCs of outstanding requests.
- Instruction FIFO: DEPTH entries, each {insn, pc}, with occupancy occ.

Reset (async, any time):
- fpc = RESET_PC.
- out_cnt = drop_cnt = occ = 0.
- insn = 0, pc = 0, valid_insn = 0, imem_req = 0.
- Requests already in flight at reset are not tracked; the memory model must also be reset.

Request issue:
- pop = valid_insn && !stall.
- imem_req = !reset && !redirect && (out_cnt + occ − pop < DEPTH).
- imem_addr = fpc.
- On imem_req && imem_gnt:
  - fpc <= fpc + 4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0).
  - out_cnt += 1.
  - push fpc onto the PC queue.

Response:
- On imem_rvalid: out_cnt −= 1 and pop the PC queue.
- If drop_cnt > 0: drop_cnt −= 1 and discard the data.
- Otherwise write {imem_rdata, queued pc} to the FIFO tail. Space is guaranteed by the credit rule; overflow is a design error and is asserted in simulation.

Output:
- insn/pc are the FIFO head; valid_insn = (occ != 0).
- When valid_insn = 0: insn = 0 (decode treats it as a noop) and pc = 0.
- Pop only when pop = 1. Under stall, insn/pc/valid_insn hold stable.

Latency and throughput:
- Grant in cycle t with rvalid in t+1 gives valid_insn=1 in cycle t+2.
- With a 1-cycle memory and no stall, sustained throughput is one instruction per cycle.

Redirect (priority over everything else in that cycle):
- fpc <= {redirect_pc[0:29], 2'b00}.
- FIFO flushed: occ = 0, so valid_insn = 0 next cycle.
- imem_req forced to 0 that cycle.
- drop_cnt <= out_cnt − (imem_rvalid ? 1 : 0); a response arriving in the redirect cycle is itself discarded.
- The PC queue still pops normally.
- Redirect while stalled: flush regardless of stall.
- Redirect on consecutive cycles: the last one wins.

Simultaneous events:
- Push and pop in the same cycle leave occ unchanged; the head advances correctly.
- When DEPTH=2 and occ=2, the write from the same-cycle pop must land correctly.

Test Plan:
- Release reset with RESET_PC=32'h00400000 and a 1-cycle memory, no stall -> addresses 0x00400000, 0x00400004, 0x00400008 granted on consecutive cycles; valid_insn rises 2 cycles after the first grant; pc follows the same sequence, one instruction per cycle.
- Hold stall high for 5 cycles starting at pc=0x00400004 -> insn/pc held; at most DEPTH outstanding+buffered; imem_req=0 once the credit is exhausted; after release, instructions resume in order with no loss or duplication.
- Redirect to 0x00401003 with 2 requests in flight -> both responses discarded; the next granted address is 0x00401000; the first valid pc is 0x00401000; valid_insn=0 in the cycle after the redirect.
- Redirect in the same cycle as imem_rvalid -> that response is discarded and drop_cnt counts only the remaining in-flight request.
- Set fpc to 32'hFFFFFFFC via redirect -> the next address is 32'h00000000.
- Assert reset mid-stream with occ=2 and valid_insn=1 -> outputs go to 0 immediately (asynchronously); after release, fetch restarts at RESET_PC.
